// File: rtl/flipflop_d_rise_1b.sv
// flipflop_d_rise_1b: single-bit rising-edge D flip-flop with asynchronous
// active-high reset. Storage primitive for the 6502 datapath; wider registers
// replicate this cell per bit. Port order (in, out, clock, reset) keeps the
// first three positions compatible with older 3-port instantiations.
module flipflop_d_rise_1b (
  input  logic in,
  output logic out,
  input  logic clock,
  input  logic reset
);

  logic out_d;
  logic out_q;

  // Next value is simply the D input; out_q only moves on a rising clock edge,
  // so there is no combinational path from in to out.
  always_comb begin
    out_d = in;
  end

  // State register: reset clears asynchronously and wins over a coincident edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) out_q <= 1'b0;
    else       out_q <= out_d;
  end

  // Q is driven directly from the flop, so it cannot glitch around the edge.
  assign out = out_q;

endmodule

// File: tb/tb_flipflop_d_rise_1b.sv
// Bench for flipflop_d_rise_1b: directed scenarios plus a random walk, all
// checked against a reference that applies the storage rules directly:
// reset forces 0 at once, a rising edge with reset low takes the pre-edge D,
// nothing else changes the stored value.
module tb_flipflop_d_rise_1b;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d   = 1'b0;
  logic q;
  logic q3;

  // reference values: exp for the reset-connected cell, exp3 for the 3-port one
  logic exp;
  logic exp3;
  bit   exp3_known = 1'b0;

  int total = 0;
  int bad   = 0;

  flipflop_d_rise_1b dut (.in(d), .out(q), .clock(clk), .reset(rst));

  // legacy positional hookup with reset tied low
  flipflop_d_rise_1b dut3 (d, q3, clk, 1'b0);

  // drive clock to v; on a rising transition the reference captures current d
  task automatic drive_clk(input logic v);
    if (v && !clk) begin
      if (!rst) exp = d;
      exp3 = d;
      exp3_known = 1'b1;
    end
    clk = v;
    #1;
  endtask

  task automatic drive_rst(input logic v);
    rst = v;
    if (v) exp = 1'b0;
    #1;
  endtask

  task automatic drive_d(input logic v);
    d = v;
    #1;
  endtask

  task automatic test_reset;
    drive_d(1'b1);
    drive_rst(1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL reset_assert got=%b exp=0", q); end
    for (int i = 0; i < 6; i++) begin
      drive_clk(~clk);
      total++;
      if (q !== 1'b0) begin bad++; $display("FAIL reset_clocked step=%0d got=%b exp=0", i, q); end
    end
    if (clk) drive_clk(1'b0);
    drive_rst(1'b0);
    drive_d(1'b0);
    drive_d(1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL reset_release_hold got=%b exp=0", q); end
    drive_clk(1'b1);
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL reset_first_edge got=%b exp=1", q); end
    drive_clk(1'b0);
  endtask

  task automatic test_load_one;
    drive_rst(1'b1);
    drive_rst(1'b0);
    drive_d(1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL load1_pre got=%b exp=0", q); end
    drive_clk(1'b1);
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL load1_edge got=%b exp=1", q); end
    drive_clk(1'b0);
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL load1_fall got=%b exp=1", q); end
  endtask

  task automatic test_hold_drop;
    drive_clk(1'b1);
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL hold_high got=%b exp=1", q); end
    drive_clk(1'b0);
    drive_d(1'b0);
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL hold_low_d0 got=%b exp=1", q); end
    drive_clk(1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL drop_edge got=%b exp=0", q); end
    drive_clk(1'b0);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL drop_fall got=%b exp=0", q); end
  endtask

  task automatic test_insensitive;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
    drive_clk(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_d(pat[i]);
      total++;
      if (q !== 1'b0) begin bad++; $display("FAIL insens_clk1 step=%0d got=%b exp=0", i, q); end
    end
    drive_clk(1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_d(pat[i]);
      total++;
      if (q !== 1'b0) begin bad++; $display("FAIL insens_clk0 step=%0d got=%b exp=0", i, q); end
    end
  endtask

  task automatic test_async_reset;
    drive_d(1'b1);
    drive_clk(1'b1);
    drive_clk(1'b0);
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL async_setup got=%b exp=1", q); end
    drive_rst(1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL async_clear got=%b exp=0", q); end
    drive_clk(1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL async_edge_in_reset got=%b exp=0", q); end
    drive_clk(1'b0);
    drive_rst(1'b0);
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL async_release got=%b exp=0", q); end
  endtask

  task automatic test_simultaneous;
    drive_d(1'b0);
    // edge and data change land in the same timestep; data arrives via NBA
    exp  = 1'b0;
    exp3 = 1'b0;
    clk = 1'b1;
    d  <= 1'b1;
    #1;
    total++;
    if (q !== 1'b0) begin bad++; $display("FAIL simul_edge got=%b exp=0", q); end
    drive_clk(1'b0);
    drive_clk(1'b1);
    total++;
    if (q !== 1'b1) begin bad++; $display("FAIL simul_next_edge got=%b exp=1", q); end
    drive_clk(1'b0);
  endtask

  task automatic test_random;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        drive_rst(1'b1);
        if ($urandom_range(0, 1) == 1) begin
          drive_d(1'($urandom));
          drive_clk(~clk);
        end
        drive_rst(1'b0);
      end else if (r <= 4) begin
        drive_d(1'($urandom));
      end else begin
        drive_clk(~clk);
      end
      total++;
      if (q !== exp) begin bad++; $display("FAIL random step=%0d got=%b exp=%b", i, q, exp); end
      if (exp3_known) begin
        total++;
        if (q3 !== exp3) begin bad++; $display("FAIL random_3port step=%0d got=%b exp=%b", i, q3, exp3); end
      end
    end
  endtask

  initial begin
    exp  = 1'bx;
    exp3 = 1'bx;
    #5;
    test_reset;
    test_load_one;
    test_hold_drop;
    test_insensitive;
    test_async_reset;
    test_simultaneous;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
